// File: rtl/uart_pkg.sv
// Constants shared by the UART TX serializer and its RX sampler counterpart.
package uart_pkg;

    localparam int unsigned DEFAULT_SAMPLES_PER_BIT = 10;
    localparam int unsigned DEFAULT_DATA_BITS       = 8;
    localparam int unsigned DEFAULT_STOP_BITS       = 1;
    localparam int unsigned BIT_INDEX_W             = 4;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    // Parity over an already-masked payload; odd=1 inverts the even result.
    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..SAMPLES_PER_BIT-1 while enabled, ticks at terminal count.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned SAMPLES_PER_BIT = DEFAULT_SAMPLES_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic bit_tick_c
);

    localparam int unsigned     CNT_W    = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(SAMPLES_PER_BIT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign bit_tick_c = en && (count_q == TERMINAL);

    // Next count: clear wins, wrap at terminal count, otherwise advance while enabled.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (bit_tick_c) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: accepts a byte via valid/ready and shifts out a start/data/stop frame, LSB first.
// Optional parity bit between data and stop is enabled by defining UART_TX_PARITY_EN.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned SAMPLES_PER_BIT = DEFAULT_SAMPLES_PER_BIT,
    parameter int unsigned DATA_BITS       = DEFAULT_DATA_BITS,
    parameter int unsigned STOP_BITS       = DEFAULT_STOP_BITS,
    parameter int unsigned PARITY_ODD      = 0
) (
    input  logic                   sampling_clock,
    input  logic                   reset,
    input  logic [7:0]             tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic                   tx,
    output logic                   tx_busy,
    output logic [BIT_INDEX_W-1:0] bit_index
);

    localparam logic [BIT_INDEX_W-1:0] LAST_DATA_IDX = BIT_INDEX_W'(DATA_BITS - 1);
    localparam logic [BIT_INDEX_W-1:0] LAST_STOP_IDX = BIT_INDEX_W'(STOP_BITS - 1);

    // Reject parameter sets the datapath cannot represent.
    if (SAMPLES_PER_BIT < 2 || DATA_BITS < 1 || DATA_BITS > 8 ||
        STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_param_check
        $error("uart_tx_serializer: unsupported parameter set");
    end

    tx_state_e              state_q,   state_d;
    logic [DATA_BITS-1:0]   shift_q,   shift_d;
    logic [BIT_INDEX_W-1:0] bit_idx_q, bit_idx_d;
    logic                   tx_q,      tx_d;
    logic                   ready_q,   ready_d;
    logic                   busy_q,    busy_d;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q,  parity_d;
`endif

    logic                   accept_c;
    logic                   bit_tick_c;
    logic [DATA_BITS-1:0]   shifted_c;

    assign shifted_c = shift_q >> 1;

    // Sample counter runs in every non-idle state and restarts on accept.
    uart_bit_timer #(
        .SAMPLES_PER_BIT (SAMPLES_PER_BIT)
    ) u_bit_timer (
        .clk        (sampling_clock),
        .rst        (reset),
        .en         (state_q != TX_IDLE),
        .clr        (accept_c),
        .bit_tick_c (bit_tick_c)
    );

    // Next-state and next-output logic; every bit change happens on a bit tick or the accept edge.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        tx_d      = tx_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        accept_c  = 1'b0;

        unique case (state_q)
            TX_IDLE: begin
                tx_d      = LINE_IDLE;
                ready_d   = 1'b1;
                busy_d    = 1'b0;
                bit_idx_d = '0;
                if (tx_valid && ready_q) begin
                    accept_c = 1'b1;
                    shift_d  = tx_data[DATA_BITS-1:0];
                    state_d  = TX_START;
                    tx_d     = LINE_START;
                    ready_d  = 1'b0;
                    busy_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_d = parity_bit(8'(tx_data[DATA_BITS-1:0]), 1'(PARITY_ODD));
`endif
                end
            end

            TX_START: begin
                if (bit_tick_c) begin
                    state_d   = TX_DATA;
                    tx_d      = shift_q[0];
                    bit_idx_d = '0;
                end
            end

            TX_DATA: begin
                if (bit_tick_c) begin
                    if (bit_idx_q == LAST_DATA_IDX) begin
                        bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = TX_PARITY;
                        tx_d      = parity_q;
`else
                        state_d   = TX_STOP;
                        tx_d      = LINE_IDLE;
`endif
                    end else begin
                        shift_d   = shifted_c;
                        tx_d      = shifted_c[0];
                        bit_idx_d = bit_idx_q + BIT_INDEX_W'(1);
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            TX_PARITY: begin
                if (bit_tick_c) begin
                    state_d   = TX_STOP;
                    tx_d      = LINE_IDLE;
                    bit_idx_d = '0;
                end
            end
`endif

            TX_STOP: begin
                tx_d = LINE_IDLE;
                if (bit_tick_c) begin
                    if (bit_idx_q == LAST_STOP_IDX) begin
                        state_d   = TX_IDLE;
                        ready_d   = 1'b1;
                        busy_d    = 1'b0;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_INDEX_W'(1);
                    end
                end
            end

            default: begin
                state_d   = TX_IDLE;
                tx_d      = LINE_IDLE;
                ready_d   = 1'b1;
                busy_d    = 1'b0;
                bit_idx_d = '0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame and returns the line to idle.
    always_ff @(posedge sampling_clock or posedge reset) begin
        if (reset) begin
            state_q   <= TX_IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= LINE_IDLE;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign tx        = tx_q;
    assign tx_ready  = ready_q;
    assign tx_busy   = busy_q;
    assign bit_index = bit_idx_q;

endmodule
